// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
// The slave modport is the controller side; the master modport is the datapath side.
// Optional performance counters appear only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if;
    logic       ex_memRead;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_useRs1;
    logic       id_useRs2;
    logic       ex_branchTaken;
    logic       dmem_req;
    logic       dmem_ready;
    logic       pc_stall;
    logic       if_id_stall;
    logic       id_ex_stall;
    logic       ex_me_stall;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       me_wb_bubble;
    logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    modport slave (
        input  ex_memRead, ex_rd, id_rs1, id_rs2, id_useRs1, id_useRs2,
        input  ex_branchTaken, dmem_req, dmem_ready,
        output pc_stall, if_id_stall, id_ex_stall, ex_me_stall,
        output if_id_flush, id_ex_flush, me_wb_bubble, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
        , output stall_cycles, flush_count
`endif
    );

    modport master (
        output ex_memRead, ex_rd, id_rs1, id_rs2, id_useRs1, id_useRs2,
        output ex_branchTaken, dmem_req, dmem_ready,
        input  pc_stall, if_id_stall, id_ex_stall, ex_me_stall,
        input  if_id_flush, id_ex_flush, me_wb_bubble, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
        , input stall_cycles, flush_count
`endif
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and
// data-memory wait stall with a sticky wait-timeout flag.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles / flush_count counters.
module pipeline_hazard_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_wcnt;
    logic       r_timeout;

    logic w_load_use;
    logic w_mem_hold;
    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_id_ex_stall;
    logic w_ex_me_stall;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_me_wb_bubble;

    assign w_load_use = hz.ex_memRead && (hz.ex_rd != 5'd0) &&
                        ((hz.id_useRs1 && (hz.ex_rd == hz.id_rs1)) ||
                         (hz.id_useRs2 && (hz.ex_rd == hz.id_rs2)));

    // In MEM_WAIT a dropped request counts as completion, so "still waiting"
    // is exactly req & ~ready in both states.
    assign w_mem_hold = hz.dmem_req && !hz.dmem_ready;

    // Combinational hazard outputs: memory hold > branch flush > load-use bubble.
    // The output decode is state-independent because the MEM_WAIT stall
    // condition equals the RUN mem_hold condition; state only drives wcnt.
    always_comb begin
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_ex_me_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_me_wb_bubble = 1'b0;
        if (rst_n) begin
            if (w_mem_hold) begin
                w_pc_stall     = 1'b1;
                w_if_id_stall  = 1'b1;
                w_id_ex_stall  = 1'b1;
                w_ex_me_stall  = 1'b1;
                w_me_wb_bubble = 1'b1;
            end else if (hz.ex_branchTaken) begin
                w_if_id_flush  = 1'b1;
                w_id_ex_flush  = 1'b1;
            end else if (w_load_use) begin
                w_pc_stall     = 1'b1;
                w_if_id_stall  = 1'b1;
                w_id_ex_flush  = 1'b1;
            end
        end
    end

    // Wait FSM: tracks the memory wait length and latches the timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_wcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_hold) begin
                        r_state <= MEM_WAIT;
                        r_wcnt  <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (r_wcnt == MEM_TIMEOUT) begin
                        r_timeout <= 1'b1;
                    end
                    if (!w_mem_hold) begin
                        r_state <= RUN;
                        r_wcnt  <= '0;
                    end else if (r_wcnt != 8'hFF) begin
                        r_wcnt  <= r_wcnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_wcnt  <= '0;
                end
            endcase
        end
    end

    assign hz.pc_stall     = w_pc_stall;
    assign hz.if_id_stall  = w_if_id_stall;
    assign hz.id_ex_stall  = w_id_ex_stall;
    assign hz.ex_me_stall  = w_ex_me_stall;
    assign hz.if_id_flush  = w_if_id_flush;
    assign hz.id_ex_flush  = w_id_ex_flush;
    assign hz.me_wb_bubble = w_me_wb_bubble;
    assign hz.mem_timeout  = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // Performance counters: stalled-PC cycles and front-end flush events, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_pc_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_if_id_flush) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign hz.stall_cycles = r_stall_cycles;
    assign hz.flush_count  = r_flush_count;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 8'd255, max dmem wait cycles before the timeout flag is set.
REQ-002 Ports (name / direction / width / meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_memRead  in  1  EX-stage instruction is a load.
- ex_rd  in  5  EX-stage destination register.
- id_rs1, id_rs2  in  5  ID-stage source registers.
- id_useRs1, id_useRs2  in  1  ID instruction reads rs1/rs2.
- ex_branchTaken  in  1  EX resolved a taken branch/jump.
- dmem_req  in  1  ME-stage load/store access valid this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_stall, if_id_stall, id_ex_stall, ex_me_stall  out  1  hold the register.
- if_id_flush, id_ex_flush  out  1  load a bubble.
- me_wb_bubble  out  1  ME/WB captures a NOP.
- mem_timeout  out  1  sticky error flag.

Function
REQ-003 States SHALL be RUN and MEM_WAIT; 1-bit state register, 8-bit wait counter wcnt.
REQ-004 load_use = ex_memRead & (ex_rd!=0) & ((id_useRs1 & ex_rd==id_rs1) | (id_useRs2 & ex_rd==id_rs2)).
REQ-005 mem_hold = dmem_req & ~dmem_ready.
REQ-006 In RUN, priority SHALL be: mem_hold > ex_branchTaken > load_use.
REQ-007 RUN + mem_hold: assert pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_bubble in the same cycle (combinational); next state MEM_WAIT; wcnt <= 1.
REQ-008 RUN + ex_branchTaken (no mem_hold): assert if_id_flush and id_ex_flush for exactly that cycle; no stalls; the branch suppresses any load_use in the same cycle.
REQ-009 RUN + load_use only: assert pc_stall, if_id_stall, id_ex_flush for that cycle (one bubble); stay in RUN.
REQ-010 MEM_WAIT: assert all four stalls plus me_wb_bubble; no flushes; branch and load_use SHALL be ignored (EX is frozen, so they are re-evaluated after resume).
REQ-011 MEM_WAIT + dmem_ready=1: outputs as RUN with mem_hold=0 in that cycle (zero-cycle resume, ME/WB captures the access); next state RUN; wcnt <= 0.
REQ-012 MEM_WAIT + dmem_ready=0: wcnt increments, saturating at 8'hFF.
REQ-013 mem_timeout SHALL be set when wcnt==MEM_TIMEOUT while in MEM_WAIT and remain 1 until reset; the wait continues (no abort).
REQ-014 Outputs other than mem_timeout SHALL be combinational from state and inputs; zero added latency.
REQ-015 dmem_req deasserting while in MEM_WAIT SHALL be treated as dmem_ready=1.

Reset
REQ-016 rst_n low: state=RUN, wcnt=0, mem_timeout=0, and every stall/flush/bubble output forced 0 regardless of inputs.
REQ-017 Reset asserted in MEM_WAIT SHALL abandon the wait immediately; after release, the block starts in RUN.

Configuration
REQ-018 Macro HAZARD_PERF_CNT_EN: when defined, adds outputs stall_cycles (32) and flush_count (32); stall_cycles increments every cycle pc_stall=1; flush_count increments every cycle if_id_flush=1; both wrap at 2^32 and reset to 0.
REQ-019 Without HAZARD_PERF_CNT_EN these ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-020 Load-use: ex_memRead=1, ex_rd=5, id_rs1=5, id_useRs1=1 -> pc_stall=if_id_stall=id_ex_flush=1 for exactly 1 cycle.
REQ-021 x0 filter: same as REQ-020 with ex_rd=0 -> all outputs 0.
REQ-022 Branch vs load-use: ex_branchTaken=1 with the load_use condition -> if_id_flush=id_ex_flush=1, pc_stall=0.
REQ-023 Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all stalls + me_wb_bubble asserted for 3 cycles; cycle 4 clear; state returns to RUN.
REQ-024 Timeout: MEM_TIMEOUT=4, ready withheld 10 cycles -> mem_timeout rises in the 5th MEM_WAIT cycle and stays high after ready; clears only on rst_n=0.
REQ-025 Reset mid-wait: rst_n=0 during MEM_WAIT -> outputs 0 at once; after release with dmem_req=0 -> state RUN, stalls 0; with HAZARD_PERF_CNT_EN, counters read 0.
